// File: rtl/wb_master_bridge.sv
// Bridges the memory controller's single-beat WB request port onto a Wishbone
// classic master cycle, with local-memory-style busy/read-data timing.
module wb_master_bridge #(
    parameter logic [3:0] ADDRESS_PREFIX = 4'h3,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] wbAddress,
    input  logic [3:0]  wbByteSelect,
    input  logic        wbEnable,
    input  logic        wbWriteEnable,
    input  logic [31:0] wbDataWrite,
    output logic [31:0] wbDataRead,
    output logic        wbBusy,
    output logic        wbError,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_CYCLE = 1'b1;

    // A disabled timeout still needs a legal (1-bit) counter width.
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LIMIT =
        COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [0:0]             stateReg;
    logic [COUNT_WIDTH-1:0] timeoutCount;
    logic                   timeoutHit;

    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (timeoutCount == COUNT_LIMIT);
    assign wbBusy     = (stateReg == STATE_CYCLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg     <= STATE_IDLE;
            timeoutCount <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= 4'h0;
            wb_adr_o     <= 32'h0;
            wb_dat_o     <= 32'h0;
            wbError      <= 1'b0;
            wbDataRead   <= 32'hFFFF_FFFF;
        end else begin
            wbError <= 1'b0;
            if (stateReg == STATE_IDLE) begin
                if (wbEnable) begin
                    stateReg     <= STATE_CYCLE;
                    timeoutCount <= '0;
                    wb_cyc_o     <= 1'b1;
                    wb_stb_o     <= 1'b1;
                    wb_we_o      <= wbWriteEnable;
                    wb_sel_o     <= wbByteSelect;
                    wb_adr_o     <= {ADDRESS_PREFIX, wbAddress};
                    wb_dat_o     <= wbDataWrite;
                end
            end else begin
                // Error beats ack; ack on the final allowed cycle beats the timeout.
                if (wb_err_i) begin
                    stateReg   <= STATE_IDLE;
                    wb_cyc_o   <= 1'b0;
                    wb_stb_o   <= 1'b0;
                    wbDataRead <= 32'hFFFF_FFFF;
                    wbError    <= 1'b1;
                end else if (wb_ack_i) begin
                    stateReg <= STATE_IDLE;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    if (!wb_we_o) begin
                        wbDataRead <= wb_dat_i;
                    end
                end else if (timeoutHit) begin
                    stateReg   <= STATE_IDLE;
                    wb_cyc_o   <= 1'b0;
                    wb_stb_o   <= 1'b0;
                    wbDataRead <= 32'hFFFF_FFFF;
                    wbError    <= 1'b1;
                end else if (timeoutCount != COUNT_MAX) begin
                    timeoutCount <= timeoutCount + 1'b1;
                end
            end
        end
    end

endmodule
